// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types for the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic req_idx_t;

    // Index of a one-hot (or zero) two-bit grant vector; zero maps to index 0.
    function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        return req_idx_t'(oh == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way one-hot picker. Round-robin via i_last by default;
//               RAM_ARB_FIXED_PRIO_EN makes requester 0 always win.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_last,
    output logic [NUM_REQ-1:0] o_pick
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_pick = 2'b00;
        if (i_req[0]) begin
            o_pick = 2'b01;
        end else if (i_req[1]) begin
            o_pick = 2'b10;
        end
    end
`else
    // On contention the requester that was not served last wins.
    always_comb begin
        o_pick = 2'b00;
        case (i_req)
            2'b01:   o_pick = 2'b01;
            2'b10:   o_pick = 2'b10;
            2'b11:   o_pick = i_last ? 2'b01 : 2'b10;
            default: o_pick = 2'b00;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one single-port synchronous RAM between two req/gnt
//               requesters with lock-based ownership and 1-cycle read return.
//               Option: RAM_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    req_idx_t          r_last;
    req_idx_t          w_gidx;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic [1:0]        r_rvalid;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_din_hold;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_din;

    rr_pick2 u_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_pick (w_pick)
    );

    // An owner keeps the port only while it both requests and locks;
    // otherwise the cycle falls through to the normal pick.
    always_comb begin
        w_gnt       = 2'b00;
        w_state_nxt = IDLE;
        if (!reset) begin
            if (r_state == OWN0 && req[0] && lock[0]) begin
                w_gnt = 2'b01;
            end else if (r_state == OWN1 && req[1] && lock[1]) begin
                w_gnt = 2'b10;
            end else begin
                w_gnt = w_pick;
            end

            if (w_gnt[0] && lock[0]) begin
                w_state_nxt = OWN0;
            end else if (w_gnt[1] && lock[1]) begin
                w_state_nxt = OWN1;
            end
        end
    end

    assign w_gidx     = onehot_to_idx(w_gnt);
    assign w_sel_addr = w_gidx ? addr1  : addr0;
    assign w_sel_din  = w_gidx ? wdata1 : wdata0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_rvalid    <= 2'b00;
            r_addr_hold <= '0;
            r_din_hold  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= w_gnt & ~we;
            if (|w_gnt) begin
                r_last      <= w_gidx;
                r_addr_hold <= w_sel_addr;
                r_din_hold  <= w_sel_din;
            end
        end
    end

    assign gnt      = w_gnt;
    assign ram_wren = |(w_gnt & we);
    assign ram_addr = (|w_gnt) ? w_sel_addr : r_addr_hold;
    assign ram_din  = (|w_gnt) ? w_sel_din  : r_din_hold;
    // A read return still in flight is suppressed while reset is asserted.
    assign rvalid   = r_rvalid & {2{~reset}};
    assign rdata    = ram_dout;

    a_gnt_onehot : assert property (@(posedge clock) $onehot0(gnt));

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Scoreboard bench for ram_port_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam logic c_FIXED = 1'b1;
`else
    localparam logic c_FIXED = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] lock = 2'b00;
    logic [1:0] we = 2'b00;
    logic [3:0] addr0 = '0;
    logic [3:0] addr1 = '0;
    logic [9:0] wdata0 = '0;
    logic [9:0] wdata1 = '0;
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [9:0] rdata;
    logic [3:0] ram_addr;
    logic [9:0] ram_din;
    logic       ram_wren;
    logic [9:0] ram_dout = '0;

    logic [9:0] ram_mem   [16];
    logic [9:0] model_mem [16];

    typedef struct {
        logic [1:0] tag;
        logic [9:0] data;
    } exp_t;

    exp_t       sb [$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] m_addr = '0;
    logic [9:0] m_din = '0;

    ram_port_arbiter #(.ADDR_W(4), .DATA_W(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .we       (we),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_wren (ram_wren),
        .ram_dout (ram_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] rq, input logic [1:0] lk,
                        input logic [1:0] wr, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [9:0] d0, input logic [9:0] d1, input logic [1:0] eg);
        exp_t e;
        reset  = rst;
        req    = rq;
        lock   = lk;
        we     = wr;
        addr0  = a0;
        addr1  = a1;
        wdata0 = d0;
        wdata1 = d1;
        @(negedge clock);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.tag  = 2'b00;
            e.data = '0;
        end
        if (rst) begin
            e.tag = 2'b00;
            sb.delete();
        end
        chk("rvalid", {30'd0, rvalid}, {30'd0, e.tag});
        if (e.tag != 2'b00) chk("rdata", {22'd0, rdata}, {22'd0, e.data});
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        chk("ram_wren", {31'd0, ram_wren}, {31'd0, |(eg & wr)});
        if (eg != 2'b00) begin
            m_addr = eg[1] ? a1 : a0;
            m_din  = eg[1] ? d1 : d0;
        end
        if (!rst) begin
            chk("ram_addr", {28'd0, ram_addr}, {28'd0, m_addr});
            chk("ram_din", {22'd0, ram_din}, {22'd0, m_din});
        end
        if ((eg & wr) != 2'b00) model_mem[m_addr] = m_din;
        e.tag  = eg & ~wr;
        e.data = model_mem[m_addr];
        sb.push_back(e);
        if (rst) begin
            m_addr = '0;
            m_din  = '0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i]   = '0;
            model_mem[i] = '0;
        end

        step(1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);

        // write from r0, read back from r1
        step(1'b0, 2'b01, 2'b00, 2'b01, 4'd3, 4'd0, 10'h155, 10'h000, 2'b01);
        step(1'b0, 2'b10, 2'b00, 2'b00, 4'd0, 4'd3, 10'h000, 10'h000, 2'b10);
        step(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);
        step(1'b0, 2'b10, 2'b00, 2'b10, 4'd0, 4'd5, 10'h000, 10'h2AA, 2'b10);

        // contended reads, no lock
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 10'h000, 10'h000,
                 (c_FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10);
        end

        // r0 holds ownership with lock, then releases
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b11, 2'b01, 2'b00, 4'd3, 4'd5, 10'h000, 10'h000, 2'b01);
        end
        step(1'b0, 2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 10'h000, 10'h000, c_FIXED ? 2'b01 : 2'b10);
        step(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);

        // owner drops req while locked: other side served same cycle
        step(1'b0, 2'b01, 2'b01, 2'b00, 4'd5, 4'd3, 10'h000, 10'h000, 2'b01);
        step(1'b0, 2'b10, 2'b01, 2'b00, 4'd5, 4'd3, 10'h000, 10'h000, 2'b10);
        step(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);

        // write then read same address on consecutive cycles
        step(1'b0, 2'b01, 2'b00, 2'b01, 4'd7, 4'd0, 10'h3C3, 10'h000, 2'b01);
        step(1'b0, 2'b10, 2'b00, 2'b00, 4'd0, 4'd7, 10'h000, 10'h000, 2'b10);
        step(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);

        // reset while r1 owns and a read is in flight; write attempt is blocked
        step(1'b0, 2'b10, 2'b10, 2'b00, 4'd7, 4'd5, 10'h000, 10'h000, 2'b10);
        step(1'b1, 2'b01, 2'b10, 2'b01, 4'd7, 4'd5, 10'h001, 10'h000, 2'b00);
        step(1'b0, 2'b11, 2'b00, 2'b00, 4'd7, 4'd5, 10'h000, 10'h000, 2'b01);
        step(1'b0, 2'b11, 2'b00, 2'b00, 4'd7, 4'd5, 10'h000, 10'h000, c_FIXED ? 2'b01 : 2'b10);
        step(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);
        step(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 10'h000, 10'h000, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
